// File: rtl/late_pipeline_regs.sv
// late_pipeline_regs: EX/MEM, MEM/WB and WB-shadow pipeline registers of the
// 5-stage RV32I core. Handles data-memory wait states and drains the pipe
// after an ecall halt commits, then parks in a sticky halted state.
module late_pipeline_regs #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_is_halt,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_din,
  output logic              dmem_read,
  output logic              dmem_write,
  input  logic [DATA_W-1:0] dmem_dout,
  input  logic              dmem_ready,
  output logic [4:0]        ex_mem_rd,
  output logic [4:0]        mem_wb_rd,
  output logic [4:0]        wb_write_rd,
  output logic              ex_mem_reg_write,
  output logic              mem_wb_reg_write,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [DATA_W-1:0] mem_wb_data,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              rf_write_enable,
  output logic [4:0]        rf_rd,
  output logic [DATA_W-1:0] rf_wd,
  output logic              stall_upstream,
  output logic              is_halted
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0] state_reg, state_next;

  // EX/MEM slot
  logic              em_valid_reg;
  logic [4:0]        em_rd_reg;
  logic              em_reg_write_reg;
  logic              em_mem_read_reg;
  logic              em_mem_write_reg;
  logic              em_mem_to_reg_reg;
  logic              em_is_halt_reg;
  logic [DATA_W-1:0] em_alu_result_reg;
  logic [DATA_W-1:0] em_rs2_data_reg;

  // MEM/WB slot
  logic              mw_valid_reg;
  logic [4:0]        mw_rd_reg;
  logic              mw_reg_write_reg;
  logic              mw_is_halt_reg;
  logic [DATA_W-1:0] mw_data_reg;

  // WB shadow (what the register file received last cycle)
  logic [4:0]        wb_rd_reg;
  logic              wb_reg_write_reg;
  logic [DATA_W-1:0] wb_data_reg;

  logic              run;
  logic              halt_commit;
  logic              mem_stall;
  logic              flush;
  logic [DATA_W-1:0] mw_data_next;

  assign run         = (state_reg == ST_RUN);
  // The halt leaves MEM/WB on this edge; everything younger is squashed.
  assign halt_commit = run & mw_valid_reg & mw_is_halt_reg;
  assign mem_stall   = em_valid_reg & (em_mem_read_reg | em_mem_write_reg) & ~dmem_ready;
  // Both slots take bubbles when draining/halted or when the halt commits.
  assign flush       = ~run | halt_commit;
  assign mw_data_next = em_mem_to_reg_reg ? dmem_dout : em_alu_result_reg;

  // Memory request; strobes are suppressed outside RUN and while reset is held
  // so nothing is issued in the reset cycle itself.
  assign dmem_addr  = em_alu_result_reg;
  assign dmem_din   = em_rs2_data_reg;
  assign dmem_read  = reset & run & em_valid_reg & em_mem_read_reg;
  assign dmem_write = reset & run & em_valid_reg & em_mem_write_reg;

  // Forwarding taps at distances 1, 2 and 3
  assign ex_mem_rd         = em_rd_reg;
  assign ex_mem_reg_write  = em_valid_reg & em_reg_write_reg;
  assign ex_mem_alu_result = em_alu_result_reg;
  assign mem_wb_rd         = mw_rd_reg;
  assign mem_wb_reg_write  = mw_valid_reg & mw_reg_write_reg;
  assign mem_wb_data       = mw_data_reg;
  assign wb_write_rd       = wb_rd_reg;
  assign wb_reg_write      = wb_reg_write_reg;
  assign wb_write_data     = wb_data_reg;

  // Register-file write port; x0 is never written
  assign rf_write_enable = reset & run & mw_valid_reg & mw_reg_write_reg & (mw_rd_reg != 5'd0);
  assign rf_rd           = mw_rd_reg;
  assign rf_wd           = mw_data_reg;

  assign stall_upstream = ~run | mem_stall;
  assign is_halted      = (state_reg == ST_HALTED);

  // Halt sequencing: RUN -> DRAIN when the halt commits, then HALTED for good
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:    if (halt_commit) state_next = ST_DRAIN;
      ST_DRAIN:  state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_reg <= ST_RUN;
    else        state_reg <= state_next;
  end

  // EX/MEM slot: capture EX, hold on a memory stall, bubble on flush
  always_ff @(posedge clk) begin
    if (!reset) begin
      em_valid_reg      <= 1'b0;
      em_rd_reg         <= 5'd0;
      em_reg_write_reg  <= 1'b0;
      em_mem_read_reg   <= 1'b0;
      em_mem_write_reg  <= 1'b0;
      em_mem_to_reg_reg <= 1'b0;
      em_is_halt_reg    <= 1'b0;
      em_alu_result_reg <= '0;
      em_rs2_data_reg   <= '0;
    end else if (flush) begin
      em_valid_reg <= 1'b0;
    end else if (!mem_stall) begin
      em_valid_reg      <= ex_valid;
      em_rd_reg         <= ex_rd;
      em_reg_write_reg  <= ex_reg_write;
      em_mem_read_reg   <= ex_mem_read;
      em_mem_write_reg  <= ex_mem_write;
      em_mem_to_reg_reg <= ex_mem_to_reg;
      em_is_halt_reg    <= ex_is_halt;
      em_alu_result_reg <= ex_alu_result;
      em_rs2_data_reg   <= ex_rs2_data;
    end
  end

  // MEM/WB slot: takes the EX/MEM result (load data when ready), bubble otherwise
  always_ff @(posedge clk) begin
    if (!reset) begin
      mw_valid_reg     <= 1'b0;
      mw_rd_reg        <= 5'd0;
      mw_reg_write_reg <= 1'b0;
      mw_is_halt_reg   <= 1'b0;
      mw_data_reg      <= '0;
    end else if (flush || mem_stall) begin
      mw_valid_reg <= 1'b0;
    end else begin
      mw_valid_reg     <= em_valid_reg;
      mw_rd_reg        <= em_rd_reg;
      mw_reg_write_reg <= em_reg_write_reg;
      mw_is_halt_reg   <= em_is_halt_reg;
      mw_data_reg      <= mw_data_next;
    end
  end

  // WB shadow: remember the register-file write just performed
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_rd_reg        <= 5'd0;
      wb_reg_write_reg <= 1'b0;
      wb_data_reg      <= '0;
    end else begin
      wb_rd_reg        <= rf_rd;
      wb_reg_write_reg <= rf_write_enable;
      wb_data_reg      <= rf_wd;
    end
  end

endmodule

// File: tb/tb_late_pipeline_regs.sv
// Testbench for late_pipeline_regs: directed timing steps plus a randomized
// instruction stream checked against an in-order program model.
module tb_late_pipeline_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_is_halt;
  logic [4:0]  ex_rd;
  logic [31:0] ex_alu_result, ex_rs2_data;
  logic [31:0] dmem_addr, dmem_din, dmem_dout;
  logic        dmem_read, dmem_write, dmem_ready;
  logic [4:0]  ex_mem_rd, mem_wb_rd, wb_write_rd, rf_rd;
  logic        ex_mem_reg_write, mem_wb_reg_write, wb_reg_write, rf_write_enable;
  logic [31:0] ex_mem_alu_result, mem_wb_data, wb_write_data, rf_wd;
  logic        stall_upstream, is_halted;

  int n_tests = 0;
  int n_fail  = 0;

  late_pipeline_regs #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_is_halt(ex_is_halt),
    .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
    .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_dout(dmem_dout), .dmem_ready(dmem_ready),
    .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd), .wb_write_rd(wb_write_rd),
    .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
    .wb_reg_write(wb_reg_write),
    .ex_mem_alu_result(ex_mem_alu_result), .mem_wb_data(mem_wb_data),
    .wb_write_data(wb_write_data),
    .rf_write_enable(rf_write_enable), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .stall_upstream(stall_upstream), .is_halted(is_halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic mw, input logic m2r, input logic hlt,
                        input logic [31:0] alu, input logic [31:0] rs2);
    ex_valid = v; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
    ex_mem_to_reg = m2r; ex_is_halt = hlt; ex_alu_result = alu; ex_rs2_data = rs2;
  endtask

  task automatic bubble();
    set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    bubble();
    dmem_ready = 1'b1; dmem_dout = 32'h0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},  {17'h0, ex_mem_rd, mem_wb_rd, wb_write_rd}, 32'h0);
    chk({tag, "_ctl"}, {22'h0, ex_mem_reg_write, mem_wb_reg_write, wb_reg_write, rf_write_enable,
                        rf_rd != 5'd0, dmem_read, dmem_write, stall_upstream, is_halted, 1'b0}, 32'h0);
    chk({tag, "_emalu"}, ex_mem_alu_result, 32'h0);
    chk({tag, "_mwdat"}, mem_wb_data, 32'h0);
    chk({tag, "_wbdat"}, wb_write_data, 32'h0);
    chk({tag, "_addr"},  dmem_addr, 32'h0);
    chk({tag, "_din"},   dmem_din, 32'h0);
  endtask

  // Program-order reference model for the random phase
  typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
  typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } mop_t;
  wr_t  wq[$];
  mop_t mq[$];
  logic [31:0] mmodel [4];
  logic [31:0] dev_mem [4];

  initial begin
    wr_t  w;
    mop_t m;
    logic em_memop, stalled;
    logic s_valid, s_rw, s_we;
    logic [4:0]  s_rd, s_wrd, prev_em_rd;
    logic [31:0] s_alu, s_wd, prev_em_alu, addr;
    int k;

    reset = 1'b1;
    bubble();
    dmem_ready = 1'b1; dmem_dout = 32'h0;

    // ---------------- reset state ----------------
    do_reset();
    chk_all_zero("reset");

    // ---------------- back-to-back ALU ops ----------------
    set_ex(1, 5'd5, 1, 0, 0, 0, 0, 32'h11, 32'h0);
    tick();
    set_ex(1, 5'd6, 1, 0, 0, 0, 0, 32'h22, 32'h0);
    chk("b2b_em_rd_n1", ex_mem_rd, 32'd5);
    chk("b2b_em_rw_n1", ex_mem_reg_write, 32'd1);
    chk("b2b_em_alu_n1", ex_mem_alu_result, 32'h11);
    tick();
    bubble();
    chk("b2b_mw_rd_n2", mem_wb_rd, 32'd5);
    chk("b2b_rf_we_n2", rf_write_enable, 32'd1);
    chk("b2b_rf_wd_n2", rf_wd, 32'h11);
    chk("b2b_em_rd_x6", ex_mem_rd, 32'd6);
    tick();
    chk("b2b_wb_rd_n3", wb_write_rd, 32'd5);
    chk("b2b_wb_dat_n3", wb_write_data, 32'h11);
    chk("b2b_wb_rw_n3", wb_reg_write, 32'd1);
    chk("b2b_rf_rd_x6", rf_rd, 32'd6);
    chk("b2b_rf_wd_x6", rf_wd, 32'h22);
    chk("b2b_rf_we_x6", rf_write_enable, 32'd1);
    tick();
    chk("b2b_wb_rd_x6", wb_write_rd, 32'd6);
    chk("b2b_rf_we_idle", rf_write_enable, 32'd0);

    // ---------------- load with 2-cycle wait ----------------
    set_ex(1, 5'd7, 1, 1, 0, 1, 0, 32'h200, 32'h0);
    dmem_ready = 1'b0;
    tick();
    bubble();
    #1;
    chk("ld_dmem_read_w1", dmem_read, 32'd1);
    chk("ld_addr", dmem_addr, 32'h200);
    chk("ld_stall_w1", stall_upstream, 32'd1);
    tick();
    chk("ld_stall_w2", stall_upstream, 32'd1);
    chk("ld_mw_bubble1", mem_wb_reg_write, 32'd0);
    dmem_ready = 1'b1; dmem_dout = 32'hDEADBEEF;
    #1;
    chk("ld_stall_done", stall_upstream, 32'd0);
    chk("ld_rf_we_wait", rf_write_enable, 32'd0);
    tick();
    dmem_dout = 32'h0;
    chk("ld_rf_we", rf_write_enable, 32'd1);
    chk("ld_rf_rd", rf_rd, 32'd7);
    chk("ld_rf_wd", rf_wd, 32'hDEADBEEF);
    chk("ld_stall_after", stall_upstream, 32'd0);
    tick();
    chk("ld_rf_we_once", rf_write_enable, 32'd0);

    // ---------------- store ----------------
    set_ex(1, 5'd9, 0, 0, 1, 0, 0, 32'h100, 32'hA5A5A5A5);
    tick();
    bubble();
    chk("st_dmem_write", dmem_write, 32'd1);
    chk("st_dmem_read", dmem_read, 32'd0);
    chk("st_addr", dmem_addr, 32'h100);
    chk("st_din", dmem_din, 32'hA5A5A5A5);
    chk("st_stall", stall_upstream, 32'd0);
    tick();
    chk("st_write_once", dmem_write, 32'd0);
    chk("st_rf_we", rf_write_enable, 32'd0);
    tick();
    chk("st_rf_we2", rf_write_enable, 32'd0);

    // ---------------- write to x0 ----------------
    set_ex(1, 5'd0, 1, 0, 0, 0, 0, 32'h33, 32'h0);
    tick();
    bubble();
    chk("x0_em_rw", ex_mem_reg_write, 32'd1);
    chk("x0_em_rd", ex_mem_rd, 32'd0);
    tick();
    chk("x0_rf_we", rf_write_enable, 32'd0);
    chk("x0_mw_rd", mem_wb_rd, 32'd0);
    tick();
    chk("x0_wb_rd", wb_write_rd, 32'd0);
    chk("x0_rf_we2", rf_write_enable, 32'd0);

    // ---------------- randomized stream ----------------
    for (int i = 0; i < 4; i++) begin
      mmodel[i] = 32'h0; dev_mem[i] = 32'h0;
    end
    bubble();
    tick(); tick();
    em_memop = 1'b0;
    for (int i = 0; i < 400; i++) begin
      // memory responds to whatever is in EX/MEM
      dmem_ready = (i >= 385) ? 1'b1 : ($urandom_range(0, 2) != 0);
      dmem_dout  = dev_mem[dmem_addr[3:2]];
      #1;
      chk("rnd_strobe", dmem_read | dmem_write, em_memop);
      chk("rnd_stall", stall_upstream, em_memop & ~dmem_ready);
      if (rf_write_enable) begin
        if (wq.size() == 0) chk("rnd_rf_unexpected", 32'd1, 32'd0);
        else begin
          w = wq.pop_front();
          chk("rnd_rf_rd", rf_rd, w.rd);
          chk("rnd_rf_wd", rf_wd, w.data);
        end
      end
      if ((dmem_read | dmem_write) && dmem_ready) begin
        if (mq.size() == 0) chk("rnd_mop_unexpected", 32'd1, 32'd0);
        else begin
          m = mq.pop_front();
          chk("rnd_mop_kind", dmem_write, m.wr);
          chk("rnd_mop_addr", dmem_addr, m.addr);
          if (m.wr) begin
            chk("rnd_mop_din", dmem_din, m.data);
            dev_mem[dmem_addr[3:2]] = dmem_din;
          end
        end
      end
      stalled = stall_upstream;
      if (!stalled) begin
        em_memop = ex_valid & (ex_mem_read | ex_mem_write);
        if (ex_valid) begin
          addr = ex_alu_result;
          if (ex_mem_write) begin
            m.wr = 1'b1; m.addr = addr; m.data = ex_rs2_data; mq.push_back(m);
            mmodel[addr[3:2]] = ex_rs2_data;
          end
          if (ex_mem_read) begin
            m.wr = 1'b0; m.addr = addr; m.data = mmodel[addr[3:2]]; mq.push_back(m);
          end
          if (ex_reg_write && ex_rd != 5'd0) begin
            w.rd = ex_rd;
            w.data = ex_mem_to_reg ? mmodel[addr[3:2]] : ex_alu_result;
            wq.push_back(w);
          end
        end
      end
      s_valid = ex_valid; s_rw = ex_reg_write; s_rd = ex_rd; s_alu = ex_alu_result;
      s_we = rf_write_enable; s_wrd = rf_rd; s_wd = rf_wd;
      prev_em_rd = ex_mem_rd; prev_em_alu = ex_mem_alu_result;
      tick();
      chk("rnd_wb_rw", wb_reg_write, s_we);
      if (s_we) begin
        chk("rnd_wb_rd", wb_write_rd, s_wrd);
        chk("rnd_wb_dat", wb_write_data, s_wd);
      end
      if (stalled) begin
        chk("rnd_mw_bubble", mem_wb_reg_write, 32'd0);
        chk("rnd_em_hold_rd", ex_mem_rd, prev_em_rd);
        chk("rnd_em_hold_alu", ex_mem_alu_result, prev_em_alu);
      end else begin
        chk("rnd_em_rw", ex_mem_reg_write, s_valid & s_rw);
        if (s_valid) begin
          chk("rnd_em_rd", ex_mem_rd, s_rd);
          chk("rnd_em_alu", ex_mem_alu_result, s_alu);
        end
        // next instruction (bubbles only at the tail so the pipe drains)
        k = (i >= 385) ? 0 : $urandom_range(0, 9);
        addr = 32'h100 + 32'(4 * $urandom_range(0, 3));
        if (k < 2)      set_ex(0, 5'($urandom_range(0, 31)), 1, 0, 0, 0, 0, $urandom, $urandom);
        else if (k < 5) set_ex(1, 5'($urandom_range(0, 31)), 1, 0, 0, 0, 0, $urandom, $urandom);
        else if (k < 8) set_ex(1, 5'($urandom_range(0, 31)), 1, 1, 0, 1, 0, addr, $urandom);
        else            set_ex(1, 5'($urandom_range(0, 31)), 0, 0, 1, 0, 0, addr, $urandom);
      end
    end
    chk("rnd_rf_pending", wq.size(), 32'd0);
    chk("rnd_mop_pending", mq.size(), 32'd0);
    dmem_ready = 1'b1;

    // ---------------- halt ----------------
    bubble();
    tick(); tick();
    set_ex(1, 5'd17, 1, 0, 0, 0, 0, 32'd10, 32'h0);
    tick();
    set_ex(1, 5'd0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    tick();
    set_ex(1, 5'd8, 1, 0, 0, 0, 0, 32'h88, 32'h0);
    chk("halt_x17_we", rf_write_enable, 32'd1);
    chk("halt_x17_rd", rf_rd, 32'd17);
    chk("halt_x17_wd", rf_wd, 32'd10);
    tick();  // H: ecall in MEM/WB, x8 in EX/MEM
    set_ex(1, 5'd9, 1, 0, 0, 0, 0, 32'h99, 32'h0);
    chk("halt_H_stall", stall_upstream, 32'd0);
    chk("halt_H_halted", is_halted, 32'd0);
    chk("halt_H_em_rd", ex_mem_rd, 32'd8);
    tick();  // H+1: DRAIN
    chk("halt_H1_stall", stall_upstream, 32'd1);
    chk("halt_H1_halted", is_halted, 32'd0);
    chk("halt_H1_em_rw", ex_mem_reg_write, 32'd0);
    chk("halt_H1_mw_rw", mem_wb_reg_write, 32'd0);
    chk("halt_H1_rf_we", rf_write_enable, 32'd0);
    tick();  // H+2: HALTED
    chk("halt_H2_halted", is_halted, 32'd1);
    chk("halt_H2_rf_we", rf_write_enable, 32'd0);
    for (int i = 0; i < 20; i++) begin
      if (i[0]) set_ex(1, 5'd8, 0, 0, 1, 0, 0, 32'h104, $urandom);
      else      set_ex(1, 5'd8, 1, 1, 0, 1, 0, 32'h108, 32'h0);
      tick();
      chk("halt_sticky", is_halted, 32'd1);
      chk("halt_stall", stall_upstream, 32'd1);
      chk("halt_quiet", {29'h0, rf_write_enable, dmem_read, dmem_write}, 32'd0);
    end

    // ---------------- reset during memory stall ----------------
    do_reset();
    chk("rs_halted_clr", is_halted, 32'd0);
    set_ex(1, 5'd12, 1, 1, 0, 1, 0, 32'h10C, 32'h0);
    dmem_ready = 1'b0;
    tick();
    bubble();
    tick();
    chk("rs_stalling", stall_upstream, 32'd1);
    reset = 1'b0;
    #1;
    chk("rs_no_strobe", {30'h0, dmem_read, rf_write_enable}, 32'd0);
    tick();
    reset = 1'b1;
    chk_all_zero("rs_after");
    dmem_ready = 1'b1;
    set_ex(1, 5'd3, 1, 0, 0, 0, 0, 32'h77, 32'h0);
    tick();
    bubble();
    chk("rs_run_em_rw", ex_mem_reg_write, 32'd1);
    tick();
    chk("rs_run_rf_we", rf_write_enable, 32'd1);
    chk("rs_run_rf_wd", rf_wd, 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
